mem_lsu: RTL and testbench

Load/store unit sitting directly upstream of the word-addressed 4 GB data memory. It accepts byte-addressed load/store requests from the MEM pipeline stage (byte, halfword, word; signed or unsigned loads), checks alignment and drives the memory's word address, write data and read/write strobes. Sub-word stores are done as read-modify-write, and load data is returned extracted and extended. The memory array has no byte enables, so all sub-word handling lives here.

---
 rtl/mem_lsu.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the MEM pipeline stage and a word-addressed
// data memory that has no byte enables.
//
// A byte-addressed request (byte/half/word, signed/unsigned load) is accepted
// in IDLE and checked for alignment. Loads and sub-word stores read the word
// first (RD). Sub-word stores then write back the merged word (WR). Word stores
// go straight to WR. Every request ends with a one-cycle completion pulse
// (RESP).
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   req_valid      request present
//   req_ready      unit can accept a request (IDLE only)
//   req_we         1 = store, 0 = load
//   req_size       0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_signed     loads: sign-extend (1) or zero-extend (0)
//   req_addr       byte address
//   req_wdata      store data, right-justified for sub-word sizes
//   resp_valid     one-cycle completion pulse
//   resp_rdata     load result; 0 for stores and errors
//   resp_err       misaligned or illegal size, valid with resp_valid
//   mem_addr       word address (req_addr[31:2])
//   mem_wdata      word written to memory
//   mem_write      memory write strobe
//   mem_read       memory read strobe
//   mem_rdata      memory read word
module mem_lsu #(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Count value of the final RD cycle; mem_rdata is sampled as it ends.
  localparam logic [2:0] LAST_RD = 3'(MEM_RD_LAT - 1);

  // Physical byte lane (0 = bits 7:0) holding the byte at this offset.
  function automatic logic [1:0] byte_lane(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  // 1 when the halfword at this offset sits in bits 31:16.
  function automatic logic half_hi(input logic [1:0] off);
    return BIG_ENDIAN ? ~off[1] : off[1];
  endfunction

  // Alignment / legal-size check on the request.
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word, right-justify and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (byte_lane(off))
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (half_hi(off)) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the read word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      2'd0: begin
        case (byte_lane(off))
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      2'd1: begin
        if (half_hi(off)) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;

  // Next state, request capture and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d       = req_we;
          size_d     = req_size;
          signed_d   = req_signed;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = req_addr[31:2];
          cnt_d      = 3'd0;
          if (misaligned(req_addr[1:0], req_size)) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_we && (req_size == 2'd2)) begin
            state_d     = WR;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (cnt_q == LAST_RD) begin
          if (we_q) begin
            state_d     = WR;
            mem_wdata_d = store_merge(mem_rdata, wdata_q, off_q, size_q);
          end else begin
            state_d      = RESP;
            resp_rdata_d = load_extract(mem_rdata, off_q, size_q, signed_q);
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and handshake follow the state being entered, so they line up
    // with the state register one cycle later.
    req_ready_d  = (state_d == IDLE);
    mem_read_d   = (state_d == RD);
    mem_write_d  = (state_d == WR);
    resp_valid_d = (state_d == RESP);
  end

  // State, captured request fields and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 30'd0;
      mem_wdata_q  <= 32'd0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu. Two instances: dut0 (MEM_RD_LAT = 1, big-endian)
// and dut1 (MEM_RD_LAT = 3, little-endian), each with its own memory behind
// it. The memory only returns real data in the last cycle of a read, so a
// unit sampling early sees a garbage pattern. Expected values come from a
// reference memory image updated with byte-lane arithmetic.
module tb_mem_lsu;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];
  logic [29:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        mem_write [2];
  logic        mem_read [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] dev_mem [2][16];
  logic [31:0] ref_mem [2][16];
  int          rd_cnt [2];

  int    n_tests = 0;
  int    n_fail  = 0;
  string ctx     = "init";

  always #5 clk = ~clk;

  mem_lsu #(.MEM_RD_LAT(LAT0), .BIG_ENDIAN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_write(mem_write[0]), .mem_read(mem_read[0]), .mem_rdata(mem_rdata[0])
  );

  mem_lsu #(.MEM_RD_LAT(LAT1), .BIG_ENDIAN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_write(mem_write[1]), .mem_read(mem_read[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory storage and read-cycle counting.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_write[k]) dev_mem[k][mem_addr[k][3:0]] <= mem_wdata[k];
      if (mem_read[k]) rd_cnt[k] <= rd_cnt[k] + 1;
      else             rd_cnt[k] <= 0;
    end
  end

  // Read data is valid only in the last cycle of the required hold time.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = 32'hA5A5_A5A5;
      if (mem_read[k] && (rd_cnt[k] == ((k == 0) ? LAT0 : LAT1) - 1))
        mem_rdata[k] = dev_mem[k][mem_addr[k][3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s %s: observed %h expected %h", ctx, tag, obs, exp);
    end
  endtask

  // Issue one request to dut k, follow it to its response and check it.
  task automatic do_req(input int k, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic [31:0] got_wdata,
                        output int waits);
    int L, nb, off, sh, n, nrd, nwr, exp_lat, exp_nrd, exp_nwr;
    logic be, err, done, got_err, excl_ok, addr_ok, quiet_ok, busy_ok;
    logic [31:0] word, mask, exp_rd, exp_wd;

    ctx  = $sformatf("dut%0d we=%0d sz=%0d a=%h", k, we, size, addr);
    L    = (k == 0) ? LAT0 : LAT1;
    be   = (k == 0);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    err  = (size == 2'd3) || ((off % nb) != 0);
    word = ref_mem[k][addr[5:2]];
    sh   = be ? (4 - nb - off) * 8 : off * 8;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    exp_rd = 32'd0; exp_wd = 32'd0; exp_nrd = 0; exp_nwr = 0;
    if (err) begin
      exp_lat = 1;
    end else if (we) begin
      exp_wd  = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      exp_nwr = 1;
      exp_nrd = (nb == 4) ? 0 : L;
      exp_lat = (nb == 4) ? 2 : L + 2;
    end else begin
      exp_rd = (word >> sh) & mask;
      if (sgn && nb < 4 && exp_rd[8 * nb - 1]) exp_rd = exp_rd | ~mask;
      exp_nrd = L;
      exp_lat = L + 1;
    end

    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid[k] = 1'b1;
    waits = 0;
    while (!req_ready[k] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("ready", 32'(req_ready[k]), 32'd1);
    @(posedge clk);

    n = 0; nrd = 0; nwr = 0; done = 1'b0; got_err = 1'b0;
    got_rdata = 32'd0; got_wdata = 32'd0;
    excl_ok = 1'b1; addr_ok = 1'b1; quiet_ok = 1'b1; busy_ok = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      req_valid[k] = 1'b0;
      n++;
      if (mem_read[k] && mem_write[k]) excl_ok = 1'b0;
      if (mem_read[k]) begin
        nrd++;
        if (mem_addr[k] !== addr[31:2]) addr_ok = 1'b0;
      end
      if (mem_write[k]) begin
        nwr++;
        got_wdata = mem_wdata[k];
        if (mem_addr[k] !== addr[31:2]) addr_ok = 1'b0;
      end
      if (req_ready[k]) busy_ok = 1'b0;
      if (resp_valid[k]) begin
        done      = 1'b1;
        got_rdata = resp_rdata[k];
        got_err   = resp_err[k];
      end else if (resp_rdata[k] !== 32'd0 || resp_err[k] !== 1'b0) begin
        quiet_ok = 1'b0;
      end
    end

    check("response_seen", 32'(done), 32'd1);
    check("latency", n, exp_lat);
    check("resp_err", 32'(got_err), 32'(err));
    check("resp_rdata", got_rdata, exp_rd);
    check("read_cycles", nrd, exp_nrd);
    check("write_cycles", nwr, exp_nwr);
    if (exp_nwr != 0) check("mem_wdata", got_wdata, exp_wd);
    check("mem_addr_ok", 32'(addr_ok), 32'd1);
    check("rd_wr_exclusive", 32'(excl_ok), 32'd1);
    check("resp_quiet", 32'(quiet_ok), 32'd1);
    check("ready_low_busy", 32'(busy_ok), 32'd1);

    if (we && !err) ref_mem[k][addr[5:2]] = exp_wd;
  endtask

  initial begin
    logic [31:0] rd, wd;
    int w;

    rst_n = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    ctx = "reset";
    for (int k = 0; k < 2; k++) begin
      check("req_ready", 32'(req_ready[k]), 32'd1);
      check("strobes", {28'd0, resp_valid[k], resp_err[k], mem_write[k], mem_read[k]}, 32'd0);
      check("resp_rdata", resp_rdata[k], 32'd0);
      check("mem_wdata", mem_wdata[k], 32'd0);
      check("mem_addr", 32'(mem_addr[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted during the WR cycle of a word store.
    ctx = "reset_mid_wr";
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0010; req_wdata = 32'h0BAD_F00D;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mem_write_in_wr", 32'(mem_write[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mem_write_falls", 32'(mem_write[0]), 32'd0);
    check("ready_in_reset", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_resp_after_reset", 32'(resp_valid[0]), 32'd0);
    end
    check("ready_after_reset", 32'(req_ready[0]), 32'd1);

    // Fill both memories through the unit with word stores.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        do_req(k, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, wd, w);

    // Word store then load, MEM_RD_LAT = 1.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, rd, wd, w);
    check("sw_wdata", wd, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, rd, wd, w);
    check("lw_data", rd, 32'hDEAD_BEEF);

    // Signed and unsigned byte loads.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h1280_34F0, rd, wd, w);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h0000_0023, 32'd0, rd, wd, w);
    check("lb_off3", rd, 32'hFFFF_FFF0);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h0000_0023, 32'd0, rd, wd, w);
    check("lbu_off3", rd, 32'h0000_00F0);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'd0, rd, wd, w);
    check("lb_off1", rd, 32'hFFFF_FF80);

    // Sub-word read-modify-write.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0030, 32'h1122_3344, rd, wd, w);
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h0000_0031, 32'h0000_00AB, rd, wd, w);
    check("sb_merge", wd, 32'h11AB_3344);
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h0000_0032, 32'h0000_BEEF, rd, wd, w);
    check("sh_merge", wd, 32'h11AB_BEEF);

    // Misaligned and illegal requests.
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h0000_0005, 32'd0, rd, wd, w);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, rd, wd, w);
    do_req(0, 1'b0, 2'd3, 1'b0, 32'h0000_0008, 32'd0, rd, wd, w);
    do_req(1, 1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h1234_5678, rd, wd, w);

    // MEM_RD_LAT = 3, little-endian lanes, back-to-back requests.
    do_req(1, 1'b1, 2'd2, 1'b0, 32'h0000_003C, 32'h89AB_CDEF, rd, wd, w);
    do_req(1, 1'b0, 2'd1, 1'b0, 32'h0000_003E, 32'd0, rd, wd, w);
    check("lhu_lat3", rd, 32'h0000_89AB);
    do_req(1, 1'b0, 2'd1, 1'b1, 32'h0000_003C, 32'd0, rd, wd, w);
    check("lh_lat3", rd, 32'hFFFF_CDEF);
    check("back_to_back_wait", w, 1);
    do_req(1, 1'b1, 2'd0, 1'b0, 32'h0000_003D, 32'h0000_0055, rd, wd, w);
    check("sb_le_merge", wd, 32'h89AB_55EF);
    check("back_to_back_wait2", w, 1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, rd, wd, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
